// File: rtl/matmul_stream_engine.sv
// matmul_stream_engine: sequential NxN signed matrix multiplier.
// Operands stream in one element per beat (A then B, row-major). One shared
// MAC builds each C element over N cycles. Results stream out row-major,
// either saturated or wrapped to OUT_W bits, with a sticky overflow flag.
module matmul_stream_engine #(
    parameter int N     = 2,
    parameter int DW    = 4,
    parameter int OUT_W = 8,
    parameter int SAT   = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             ena,
    input  logic             clear,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [OUT_W-1:0] out_data,
    output logic             out_last,
    output logic             busy,
    output logic             ovf
);
    localparam int NN    = N * N;
    localparam int IDX_W = $clog2(NN);
    localparam int IW    = $clog2(N);
    localparam int ACC_W = 2 * DW + $clog2(N);
    // Comparison width wide enough for both the accumulator and the output range
    localparam int CW    = ((ACC_W > OUT_W) ? ACC_W : OUT_W) + 1;
    localparam logic signed [CW-1:0] OUT_MAX = CW'((64'sd1 <<< (OUT_W - 1)) - 64'sd1);
    localparam logic signed [CW-1:0] OUT_MIN = ~OUT_MAX;

    typedef enum logic [1:0] {S_LOAD_A, S_LOAD_B, S_MAC, S_OUT} state_t;

    state_t                  state_q, state_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IW-1:0]           i_q, i_d, j_q, j_d, k_q, k_d;
    logic signed [ACC_W-1:0] acc_q, acc_d;
    logic                    ovf_q, ovf_d;
    logic [OUT_W-1:0]        out_data_q, out_data_d;
    logic signed [DW-1:0]    a_mem_q [NN];
    logic signed [DW-1:0]    b_mem_q [NN];
    logic                    a_we, b_we;

    logic [IDX_W-1:0]        a_addr, b_addr;
    logic signed [2*DW-1:0]  prod;
    logic signed [ACC_W-1:0] prod_ext, acc_sum;
    logic signed [CW-1:0]    sum_w;
    logic [OUT_W-1:0]        conv_data;
    logic                    not_repr;
    logic                    last_i, last_j, last_k, accept;

    assign last_i = (i_q == IW'(N - 1));
    assign last_j = (j_q == IW'(N - 1));
    assign last_k = (k_q == IW'(N - 1));

    assign in_ready  = rst_n & ena & ((state_q == S_LOAD_A) | (state_q == S_LOAD_B));
    assign accept    = in_valid & in_ready;
    assign out_valid = ena & (state_q == S_OUT);
    assign out_last  = out_valid & last_i & last_j;
    assign busy      = (state_q == S_MAC) | (state_q == S_OUT);
    assign ovf       = ovf_q;
    assign out_data  = out_data_q;

    // MAC datapath: full-precision product, sign-extended into the accumulator,
    // then range-checked and converted to the output width
    always_comb begin
        a_addr   = IDX_W'(i_q) * IDX_W'(N) + IDX_W'(k_q);
        b_addr   = IDX_W'(k_q) * IDX_W'(N) + IDX_W'(j_q);
        prod     = a_mem_q[a_addr] * b_mem_q[b_addr];
        prod_ext = {{(ACC_W - 2 * DW){prod[2*DW-1]}}, prod};
        acc_sum  = acc_q + prod_ext;
        sum_w    = {{(CW - ACC_W){acc_sum[ACC_W-1]}}, acc_sum};
        not_repr = (sum_w > OUT_MAX) || (sum_w < OUT_MIN);
        conv_data = sum_w[OUT_W-1:0];
        if (SAT != 0) begin
            if (sum_w > OUT_MAX) begin
                conv_data = OUT_MAX[OUT_W-1:0];
            end else if (sum_w < OUT_MIN) begin
                conv_data = OUT_MIN[OUT_W-1:0];
            end
        end
    end

    // Next-state logic; clear wins over every handshake, ena=0 freezes everything
    always_comb begin
        state_d    = state_q;
        idx_d      = idx_q;
        i_d        = i_q;
        j_d        = j_q;
        k_d        = k_q;
        acc_d      = acc_q;
        ovf_d      = ovf_q;
        out_data_d = out_data_q;
        a_we       = 1'b0;
        b_we       = 1'b0;
        if (clear) begin
            state_d = S_LOAD_A;
            idx_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            acc_d   = '0;
            ovf_d   = 1'b0;
        end else if (ena) begin
            case (state_q)
                S_LOAD_A: begin
                    if (accept) begin
                        a_we = 1'b1;
                        if (idx_q == '0) ovf_d = 1'b0;
                        if (idx_q == IDX_W'(NN - 1)) begin
                            idx_d   = '0;
                            state_d = S_LOAD_B;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_LOAD_B: begin
                    if (accept) begin
                        b_we = 1'b1;
                        if (idx_q == IDX_W'(NN - 1)) begin
                            idx_d   = '0;
                            i_d     = '0;
                            j_d     = '0;
                            k_d     = '0;
                            acc_d   = '0;
                            state_d = S_MAC;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end
                end
                S_MAC: begin
                    acc_d = acc_sum;
                    if (last_k) begin
                        // Result is latched here so it is stable for the whole OUT phase
                        k_d        = '0;
                        out_data_d = conv_data;
                        if (not_repr) ovf_d = 1'b1;
                        state_d    = S_OUT;
                    end else begin
                        k_d = k_q + IW'(1);
                    end
                end
                S_OUT: begin
                    if (out_ready) begin
                        acc_d = '0;
                        if (last_i && last_j) begin
                            i_d     = '0;
                            j_d     = '0;
                            state_d = S_LOAD_A;
                        end else begin
                            if (last_j) begin
                                j_d = '0;
                                i_d = i_q + IW'(1);
                            end else begin
                                j_d = j_q + IW'(1);
                            end
                            state_d = S_MAC;
                        end
                    end
                end
                default: state_d = S_LOAD_A;
            endcase
        end
    end

    // Control and datapath registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_LOAD_A;
            idx_q      <= '0;
            i_q        <= '0;
            j_q        <= '0;
            k_q        <= '0;
            acc_q      <= '0;
            ovf_q      <= 1'b0;
            out_data_q <= '0;
        end else begin
            state_q    <= state_d;
            idx_q      <= idx_d;
            i_q        <= i_d;
            j_q        <= j_d;
            k_q        <= k_d;
            acc_q      <= acc_d;
            ovf_q      <= ovf_d;
            out_data_q <= out_data_d;
        end
    end

    // Operand storage: one element written per accepted beat at the load index
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int e = 0; e < NN; e++) begin
                a_mem_q[e] <= '0;
                b_mem_q[e] <= '0;
            end
        end else begin
            if (a_we) a_mem_q[idx_q] <= in_data;
            if (b_we) b_mem_q[idx_q] <= in_data;
        end
    end
endmodule

// File: doc/matmul_stream_engine.md
Name: matmul_stream_engine

Overview:
- Parametrised, sequential NxN signed matrix multiplier (C = A x B) that replaces the fixed 2x2 combinational multiplier.
- Operands are loaded one element per accepted beat over a valid/ready stream: A first, then B, each row-major.
- One shared MAC computes each C element in N cycles. Results leave row-major on a valid/ready output stream, with optional saturation and a sticky overflow flag.
- Sits between the pin-level input demux and the output pin registers of the tile.

Parameters:
- N, 2, matrix dimension; legal range 2..4.
- DW, 4, signed element width of A and B; legal range 2..8.
- OUT_W, 8, signed result width on out_data; legal range 4..16.
- SAT, 1, 1 = clamp results to the OUT_W signed range; 0 = truncate (wrap) to OUT_W LSBs.

Ports:
- clk  in  1  clock
- rst_n  in  1  reset, asynchronous, active-low
- ena  in  1  global enable; 0 stalls the block
- clear  in  1  synchronous abort; returns the block to LOAD_A
- in_valid  in  1  input element valid
- in_ready  out  1  block can accept an element
- in_data  in  DW  signed element of A or B
- out_valid  out  1  result element valid
- out_ready  in  1  downstream accepts the result
- out_data  out  OUT_W  signed C element, row-major order
- out_last  out  1  high with C[N-1][N-1]
- busy  out  1  high in MAC or OUT state
- ovf  out  1  sticky: at least one result of the current matrix clamped or wrapped

Behaviour:
- Accumulator width ACC_W = 2*DW + clog2(N).
  - Products are full-precision signed, sign-extended before accumulation; the accumulator never overflows.
- State machine and transitions:
  - LOAD_A:
    - in_ready = ena.
    - Each handshake (in_valid & in_ready & ena) writes A[idx] and increments idx.
    - After N*N elements, go to LOAD_B with idx = 0.
  - LOAD_B: same as LOAD_A for B. After the last element, go to MAC with i = j = k = 0 and acc = 0.
  - MAC:
    - One cycle per k: acc += A[i][k]*B[k][j].
    - Exactly N cycles, then go to OUT.
    - in_ready = 0.
  - OUT:
    - out_valid = 1. out_data is acc converted to OUT_W and held stable until the handshake.
    - On out_valid & out_ready & ena:
      - If (i,j) = (N-1,N-1), go to LOAD_A.
      - Otherwise advance j (wrap to 0, then increment i), clear acc, and go to MAC.
- Latency:
  - Last B element accepted at edge t: out_valid rises after edge t+N.
  - Each later element takes N cycles after the previous output handshake.
  - A full matrix takes N*N*(N+1) cycles plus load time, with no backpressure.
- Conversion to OUT_W:
  - SAT=1: values above 2^(OUT_W-1)-1 clamp to max; values below -2^(OUT_W-1) clamp to min.
  - SAT=0: take the low OUT_W bits.
  - Either way, ovf sets when the value is not representable in OUT_W.
- ovf lifecycle:
  - Set in the OUT cycle where the condition occurs.
  - Cleared on the first accepted A element of the next matrix, on clear, and on reset.
- ena = 0:
  - in_ready and out_valid read 0.
  - No state, index, accumulator or flag changes.
  - out_data holds its value.
- clear: has priority over every handshake in the same cycle. Next state is LOAD_A; indices, acc and ovf are zeroed; operand storage is not cleared.
- Reset values, all asynchronous:
  - State LOAD_A; all indices and acc are 0.
  - in_ready = 0 while rst_n is low.
  - out_valid = 0, out_data = 0, out_last = 0, busy = 0, ovf = 0.
  - Operand storage is reset to 0.
- Reset or clear in the middle of loading or computing discards the partial matrix. No partial results are emitted.
- out_last is asserted only together with out_valid for C[N-1][N-1].
- busy = 1 in MAC and OUT.
- Output side: out_valid must not drop without a handshake, except when ena = 0.

Test Plan:
- Basic 2x2 (N=2, DW=2, OUT_W=8): A = 1,-1,0,1; B = 1,1,-1,0 -> out_data sequence 2,1,-1,0; out_last on the 4th element; ovf = 0; first out_valid exactly 2 cycles after the last B beat.
- Saturation (N=2, DW=4, OUT_W=4, SAT=1): all A = 7, all B = 7 -> four outputs of 7 with ovf = 1. Then all A = -8, all B = 7 -> four outputs of -8; ovf clears on the first A beat and re-sets.
- Wrap mode (same operands, SAT=0): sum 98 = 0x62 -> out_data = 2 and ovf = 1. Max-magnitude 3x3 (N=3, DW=8, OUT_W=16): all -128 x all -128 -> each output is 49152, saturating to 32767.
- Backpressure and ena: hold out_ready = 0 for 5 cycles on the 2nd result -> out_data stable and no index advance. Drop ena mid-MAC for 3 cycles -> results identical, latency +3.
- Abort and reset: clear asserted mid-LOAD_B, then reload the basic 2x2 -> correct 2,1,-1,0. Assert rst_n low during OUT -> all outputs 0 immediately; reload gives the correct result.
- Input throttling: in_valid toggles randomly during the load -> only handshaken beats are stored; result matches the golden model for random N=4, DW=3 matrices.
